multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Main sequencing FSM for the multi-cycle RV32I core. Walks each instruction through fetch, decode, execute, memory and writeback. Drives the register file write enable, memory strobes, PC update and mux selects. Owns halt detection: raises is_ecall toward the register file and enters a terminal HALT state when the register file reports is_halted. Also keeps a retired-instruction counter.

Parameters:
RESET_STATE, 3'd0 (IF), state entered on reset.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
opcode  input  7  instr[6:0] from instruction register
mem_ready  input  1  memory completes current read/write this cycle
is_halted  input  1  register file halt flag (ecall with x17==10), combinational
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if branch taken (datapath gates with compare)
pc_src  output  2  0=PC+4, 1=ALU result, 2=ALU result & ~1
i_or_d  output  1  memory address: 0=PC, 1=ALU out
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  latch instruction register
reg_write  output  1  register file write_enable
wb_src  output  2  0=ALU, 1=MDR, 2=PC+4
alu_op  output  2  0=add, 1=branch compare, 2=funct-decoded
is_ecall  output  1  to register file halt logic
halted  output  1  core halted, sticky until reset
state  output  3  current state, debug
retired  output  CNT_W  retired-instruction count

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Values 6 and 7 recover to IF on the next edge.
- Reset (async): state=IF, retired=0, halted=0. All outputs are a Moore/Mealy decode of state plus inputs, so outputs not asserted by IF are 0 during reset.
- IF: mem_read=1, i_or_d=0.
  - mem_ready=1: ir_write=1, go to ID.
  - Otherwise stay in IF with ir_write=0.
- ID, opcode ECALL 1110011: is_ecall=1.
  - is_halted=1: go to HALT, no PC write, retired += 1.
  - Otherwise: pc_write=1, pc_src=0, go to IF, retired += 1.
- ID, unknown opcode: treated as NOP. pc_write=1, pc_src=0, go to IF, retired += 1.
- ID, other opcodes: go to EX.
- EX, R 0110011 / I-ALU 0010011: alu_op=2, go to WB.
- EX, LOAD 0000011 / STORE 0100011: alu_op=0, go to MEM.
- EX, BRANCH 1100011: alu_op=1, pc_write_cond=1, pc_src=1, pc_write=0.
  - Datapath selects PC+4 when the branch is not taken.
  - Go to IF, retired += 1.
- EX, JAL 1101111 / JALR 1100111: alu_op=0, go to WB.
- MEM: i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE. Strobes are held until mem_ready.
  - mem_ready, LOAD: go to WB.
  - mem_ready, STORE: pc_write=1, pc_src=0, go to IF, retired += 1.
  - No mem_ready: stay in MEM.
- WB: reg_write=1, wb_src=1 for LOAD, 2 for JAL/JALR, else 0. pc_write=1, go to IF, retired += 1.
  - pc_src=1 for JAL, 2 for JALR, else 0.
- HALT: all strobes 0, halted=1, retired frozen. Only reset exits.
- Latency with zero-wait memory:
  - ALU op and jump: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - ECALL: 2 cycles.
  - Each wait cycle adds 1.
- reset mid-operation (any state, including MEM with strobe high): strobes drop combinationally with reset, next state IF.
- retired wraps modulo 2^CNT_W without saturation.
- Opcode is sampled only from the IR, so it is stable from ID to end of instruction. mem_ready outside IF/MEM is ignored.

Test Plan:
- Reset asserted mid-cycle in MEM with mem_write=1 -> mem_write falls without waiting for clk, state=0, retired=0.
- R-type 0110011 with mem_ready tied 1 -> state sequence 0,1,2,4,0. reg_write=1 only in WB, wb_src=0, retired 0->1.
- LOAD with mem_ready low for 2 cycles in IF and 3 in MEM -> 10 cycles total. mem_read held high while waiting, i_or_d=1 in MEM, wb_src=1 in WB.
- BRANCH then JALR -> BRANCH: pc_write_cond=1 in EX, 3 cycles. JALR: WB has pc_src=2, wb_src=2. retired=2.
- ECALL with is_halted=0, then ECALL with is_halted=1 -> first returns to IF. Second: is_ecall=1 in ID, then state=5, halted=1. retired frozen at 2 over 20 further cycles; mem_read stays 0.
- Force retired to 0xFFFFFFFF, retire one STORE -> retired=0x00000000.

Source files
------------

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: IF/ID/EX/MEM/WB plus terminal HALT.
// Outputs are a decode of the current state, the IR opcode and the memory/halt handshakes.
module multicycle_controller #(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             is_halted,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       wb_src,
    output logic [1:0]       alu_op,
    output logic             is_ecall,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             op_known;

    // ECALL is resolved in ID, so it is not part of the set that proceeds to EX
    always_comb begin
        op_known = 1'b0;
        case (opcode)
            OP_R, OP_IALU, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: op_known = 1'b1;
            default:                    op_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= state_e'(RESET_STATE);
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        wb_src        = 2'd0;
        alu_op        = 2'd0;
        is_ecall      = 1'b0;
        halted        = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                if (opcode == OP_ECALL) begin
                    is_ecall = 1'b1;
                    retire   = 1'b1;
                    if (is_halted) begin
                        state_d = S_HALT;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end
                end else if (op_known) begin
                    state_d = S_EX;
                end else begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_IF;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_R, OP_IALU: begin
                        alu_op  = 2'd2;
                        state_d = S_WB;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    // Datapath gates pc_write_cond with the compare result
                    OP_BRANCH: begin
                        alu_op        = 2'd1;
                        pc_write_cond = 1'b1;
                        pc_src        = 2'd1;
                        retire        = 1'b1;
                        state_d       = S_IF;
                    end
                    OP_JAL, OP_JALR: state_d = S_WB;
                    default:         state_d = S_IF;
                endcase
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end else if (opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_IF;
                    end
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = S_IF;
                case (opcode)
                    OP_LOAD: wb_src = 2'd1;
                    OP_JAL: begin
                        wb_src = 2'd2;
                        pc_src = 2'd1;
                    end
                    OP_JALR: begin
                        wb_src = 2'd2;
                        pc_src = 2'd2;
                    end
                    default: wb_src = 2'd0;
                endcase
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IF;
        endcase
    end

    assign retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
    assign retired   = retired_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: per-cycle expectations are queued by the
// driver and popped/compared by a negedge monitor; a narrow-counter instance checks wrap.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] ret;
        logic        pw;
        logic        pwc;
        logic [1:0]  pcs;
        logic        iod;
        logic        mrd;
        logic        mwr;
        logic        irw;
        logic        rw;
        logic [1:0]  wbs;
        logic [1:0]  alu;
        logic        ec;
        logic        h;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        mem_ready = 1'b0;
    logic        is_halted = 1'b0;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic        is_ecall, halted;
    logic [1:0]  pc_src, wb_src, alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        w_pw, w_pwc, w_iod, w_mrd, w_mwr, w_irw, w_rw, w_ec, w_h;
    logic [1:0]  w_pcs, w_wbs, w_alu;
    logic [2:0]  w_st;
    logic [2:0]  w_ret;

    int tests_run = 0;
    int tests_failed = 0;
    obs_t  q_exp[$];
    string q_name[$];
    obs_t  act;

    always #5 clk = ~clk;

    multicycle_controller #(.RESET_STATE(3'd0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .is_halted(is_halted),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .wb_src(wb_src), .alu_op(alu_op), .is_ecall(is_ecall), .halted(halted),
        .state(state), .retired(retired)
    );

    multicycle_controller #(.RESET_STATE(3'd0), .CNT_W(3)) u_wrap (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .is_halted(is_halted),
        .pc_write(w_pw), .pc_write_cond(w_pwc), .pc_src(w_pcs), .i_or_d(w_iod),
        .mem_read(w_mrd), .mem_write(w_mwr), .ir_write(w_irw), .reg_write(w_rw),
        .wb_src(w_wbs), .alu_op(w_alu), .is_ecall(w_ec), .halted(w_h),
        .state(w_st), .retired(w_ret)
    );

    always_comb act = {state, retired, pc_write, pc_write_cond, pc_src, i_or_d, mem_read,
                       mem_write, ir_write, reg_write, wb_src, alu_op, is_ecall, halted};

    // Args in struct order: state, retired, pc_write, pc_write_cond, pc_src, i_or_d, mem_read,
    // mem_write, ir_write, reg_write, wb_src, alu_op, is_ecall, halted
    function automatic obs_t E(input logic [2:0] st, input logic [31:0] ret,
                               input logic pw, input logic pwc, input logic [1:0] pcs,
                               input logic iod, input logic mrd, input logic mwr,
                               input logic irw, input logic rw, input logic [1:0] wbs,
                               input logic [1:0] alu, input logic ec, input logic h);
        return {st, ret, pw, pwc, pcs, iod, mrd, mwr, irw, rw, wbs, alu, ec, h};
    endfunction

    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            obs_t  e;
            string nm;
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            tests_run++;
            if (act !== e) begin
                tests_failed++;
                $display("FAIL %s: got %h expected %h (st %0d/%0d ret %0d/%0d)",
                         nm, act, e, act.st, e.st, act.ret, e.ret);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drive one cycle's inputs, queue its expected outputs, advance to the next cycle
    task automatic cyc(input string nm, input logic [6:0] op, input logic mr, input logic hal,
                       input obs_t e);
        opcode    = op;
        mem_ready = mr;
        is_halted = hal;
        q_exp.push_back(e);
        q_name.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        opcode    = 7'd0;
        mem_ready = 1'b0;
        is_halted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_mem_write", {31'd0, mem_write}, 32'd0);

        // R-type, zero-wait: 0,1,2,4,0
        cyc("r_if",  OP_R, 1, 0, E(0, 0, 0,0,0, 0,1,0,1,0, 0,0, 0,0));
        cyc("r_id",  OP_R, 1, 0, E(1, 0, 0,0,0, 0,0,0,0,0, 0,0, 0,0));
        cyc("r_ex",  OP_R, 1, 0, E(2, 0, 0,0,0, 0,0,0,0,0, 0,2, 0,0));
        cyc("r_wb",  OP_R, 1, 0, E(4, 0, 1,0,0, 0,0,0,0,1, 0,0, 0,0));

        // STORE stalled in MEM, reset lands mid-cycle
        cyc("st_if",  OP_STORE, 1, 0, E(0, 1, 0,0,0, 0,1,0,1,0, 0,0, 0,0));
        cyc("st_id",  OP_STORE, 1, 0, E(1, 1, 0,0,0, 0,0,0,0,0, 0,0, 0,0));
        cyc("st_ex",  OP_STORE, 0, 0, E(2, 1, 0,0,0, 0,0,0,0,0, 0,0, 0,0));
        cyc("st_mem", OP_STORE, 0, 0, E(3, 1, 0,0,0, 1,0,1,0,0, 0,0, 0,0));
        #2;
        chk("mid_mem_write_before", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_mem_write_after", {31'd0, mem_write}, 32'd0);
        chk("mid_state", {29'd0, state}, 32'd0);
        chk("mid_retired", retired, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // LOAD: 2 IF waits, 3 MEM waits -> 10 cycles
        for (int i = 0; i < 2; i++)
            cyc("ld_if_wait", OP_LOAD, 0, 0, E(0, 0, 0,0,0, 0,1,0,0,0, 0,0, 0,0));
        cyc("ld_if",  OP_LOAD, 1, 0, E(0, 0, 0,0,0, 0,1,0,1,0, 0,0, 0,0));
        cyc("ld_id",  OP_LOAD, 0, 0, E(1, 0, 0,0,0, 0,0,0,0,0, 0,0, 0,0));
        cyc("ld_ex",  OP_LOAD, 0, 0, E(2, 0, 0,0,0, 0,0,0,0,0, 0,0, 0,0));
        for (int i = 0; i < 3; i++)
            cyc("ld_mem_wait", OP_LOAD, 0, 0, E(3, 0, 0,0,0, 1,1,0,0,0, 0,0, 0,0));
        cyc("ld_mem", OP_LOAD, 1, 0, E(3, 0, 0,0,0, 1,1,0,0,0, 0,0, 0,0));
        cyc("ld_wb",  OP_LOAD, 1, 0, E(4, 0, 1,0,0, 0,0,0,0,1, 1,0, 0,0));
        cyc("ld_done", OP_LOAD, 0, 0, E(0, 1, 0,0,0, 0,1,0,0,0, 0,0, 0,0));

        // BRANCH (3 cycles), JALR (4 cycles), unknown opcode as NOP
        do_reset();
        cyc("br_if",   OP_BRANCH, 1, 0, E(0, 0, 0,0,0, 0,1,0,1,0, 0,0, 0,0));
        cyc("br_id",   OP_BRANCH, 1, 0, E(1, 0, 0,0,0, 0,0,0,0,0, 0,0, 0,0));
        cyc("br_ex",   OP_BRANCH, 1, 0, E(2, 0, 0,1,1, 0,0,0,0,0, 0,1, 0,0));
        cyc("jalr_if", OP_JALR, 1, 0, E(0, 1, 0,0,0, 0,1,0,1,0, 0,0, 0,0));
        cyc("jalr_id", OP_JALR, 1, 0, E(1, 1, 0,0,0, 0,0,0,0,0, 0,0, 0,0));
        cyc("jalr_ex", OP_JALR, 1, 0, E(2, 1, 0,0,0, 0,0,0,0,0, 0,0, 0,0));
        cyc("jalr_wb", OP_JALR, 1, 0, E(4, 1, 1,0,2, 0,0,0,0,1, 2,0, 0,0));
        cyc("nop_if",  OP_LUI, 1, 0, E(0, 2, 0,0,0, 0,1,0,1,0, 0,0, 0,0));
        cyc("nop_id",  OP_LUI, 1, 0, E(1, 2, 1,0,0, 0,0,0,0,0, 0,0, 0,0));
        cyc("nop_done", OP_LUI, 0, 0, E(0, 3, 0,0,0, 0,1,0,0,0, 0,0, 0,0));

        // ECALL without halt, then ECALL with halt
        do_reset();
        cyc("ec0_if", OP_ECALL, 1, 0, E(0, 0, 0,0,0, 0,1,0,1,0, 0,0, 0,0));
        cyc("ec0_id", OP_ECALL, 1, 0, E(1, 0, 1,0,0, 0,0,0,0,0, 0,0, 1,0));
        cyc("ec1_if", OP_ECALL, 1, 0, E(0, 1, 0,0,0, 0,1,0,1,0, 0,0, 0,0));
        cyc("ec1_id", OP_ECALL, 1, 1, E(1, 1, 0,0,0, 0,0,0,0,0, 0,0, 1,0));
        for (int i = 0; i < 20; i++)
            cyc("halt", OP_ECALL, 1'(i % 2), 1'(i % 3 == 0),
                E(5, 2, 0,0,0, 0,0,0,0,0, 0,0, 0,1));

        // Counter wrap on the 3-bit instance: 8 zero-wait STOREs
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc("wr_if",  OP_STORE, 1, 0, E(0, 32'(i), 0,0,0, 0,1,0,1,0, 0,0, 0,0));
            cyc("wr_id",  OP_STORE, 1, 0, E(1, 32'(i), 0,0,0, 0,0,0,0,0, 0,0, 0,0));
            cyc("wr_ex",  OP_STORE, 1, 0, E(2, 32'(i), 0,0,0, 0,0,0,0,0, 0,0, 0,0));
            cyc("wr_mem", OP_STORE, 1, 0, E(3, 32'(i), 1,0,0, 1,0,1,0,0, 0,0, 0,0));
            if (i == 6) chk("wrap_at_max", {29'd0, w_ret}, 32'd7);
        end
        chk("wrap_to_zero", {29'd0, w_ret}, 32'd0);
        cyc("wr_done", OP_STORE, 0, 0, E(0, 8, 0,0,0, 0,1,0,0,0, 0,0, 0,0));

        repeat (2) @(posedge clk);
        if (q_exp.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
